// File: rtl/serial_tx_fifo.sv
// Serial transmitter fed by a small word FIFO: programmable bit period, optional
// start/stop framing, selectable bit order and a mid-bit companion clock.
module serial_tx_fifo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DIV_RST   = 1,
    parameter int unsigned FRAMED    = 1,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Sample,
    input  logic [DATA_W-1:0]          DataIn,
    input  logic                       StartTx,
    input  logic                       ConfigDiv,
    input  logic [DIV_W-1:0]           DivIn,
    input  logic                       ClrOvf,
    output logic                       Dout,
    output logic                       ClkTx,
    output logic                       TxBusy,
    output logic                       TxDone,
    output logic                       Empty,
    output logic                       Full,
    output logic [$clog2(DEPTH):0]     Level,
    output logic                       Overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]         level_q, level_d;
    logic                ovf_q, ovf_d;

    logic                empty_c, full_c, push_c, pop_c;
    logic                bit_end_c, frame_end_c, busy_c;
    logic [DIV_W:0]      half_c;

    assign empty_c   = (level_q == '0);
    assign full_c    = (level_q == (AW+1)'(DEPTH));
    assign busy_c    = (state_q != IDLE);
    assign bit_end_c = (cnt_q == div_q);
    assign half_c    = ((DIV_W+1)'(div_q) + (DIV_W+1)'(1)) >> 1;

    // Frame sequencer: bit timing, shifting, and pops at idle or frame end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pop_c       = 1'b0;
        frame_end_c = 1'b0;

        if (busy_c) begin
            cnt_d = bit_end_c ? '0 : cnt_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (StartTx && !empty_c) begin
                    pop_c = 1'b1;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_W - 1)) begin
                        bit_d = '0;
                        if (FRAMED != 0) begin
                            state_d = STOP;
                        end else begin
                            frame_end_c = 1'b1;
                        end
                    end
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    frame_end_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_end_c) begin
            state_d = IDLE;
            if (StartTx && !empty_c) begin
                pop_c = 1'b1;
            end
        end

        if (pop_c) begin
            shift_d = mem_q[rd_q];
            state_d = (FRAMED != 0) ? START : DATA;
            cnt_d   = '0;
            bit_d   = '0;
        end
    end

    // FIFO bookkeeping, divider load and sticky overflow
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        div_d   = div_q;

        push_c = Sample && (!full_c || pop_c);

        if (push_c) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop_c) begin
            rd_d = rd_q + AW'(1);
        end
        if (push_c && !pop_c) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!push_c && pop_c) begin
            level_d = level_q - (AW+1)'(1);
        end

        if (ClrOvf) begin
            ovf_d = 1'b0;
        end
        if (Sample && full_c && !pop_c) begin
            ovf_d = 1'b1;
        end

        if (ConfigDiv && (state_q == IDLE)) begin
            div_d = (DivIn == '0) ? DIV_W'(1) : DivIn;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            div_q   <= DIV_W'(DIV_RST);
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level
    always_ff @(posedge Clk) begin
        if (push_c) begin
            mem_q[wr_q] <= DataIn;
        end
    end

    always_comb begin
        Dout = (FRAMED != 0);
        case (state_q)
            IDLE:    Dout = (FRAMED != 0);
            START:   Dout = 1'b0;
            DATA:    Dout = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];
            STOP:    Dout = 1'b1;
            default: Dout = (FRAMED != 0);
        endcase
    end

    assign ClkTx    = busy_c && ((DIV_W+1)'(cnt_q) >= half_c);
    assign TxBusy   = busy_c;
    assign TxDone   = frame_end_c;
    assign Empty    = empty_c;
    assign Full     = full_c;
    assign Level    = level_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors rebuild
// serial frames at ClkTx rising edges and compare at TxDone.
module tb_serial_tx_fifo;

    logic        Clk = 1'b0;
    logic        Reset;
    always #5 Clk = ~Clk;

    // framed, LSB-first instance
    logic        sample, start_tx, cfg_div, clr_ovf;
    logic [31:0] data_in;
    logic [7:0]  div_in;
    logic        dout, clk_tx, tx_busy, tx_done, empty, full, overflow;
    logic [2:0]  level;

    // raw, MSB-first instance
    logic        s2_sample, s2_start, s2_cfg, s2_clr;
    logic [31:0] s2_data;
    logic [7:0]  s2_div;
    logic        d2_dout, d2_clk, d2_busy, d2_done, d2_empty, d2_full, d2_ovf;
    logic [2:0]  d2_level;

    serial_tx_fifo dut (
        .Clk(Clk), .Reset(Reset), .Sample(sample), .DataIn(data_in),
        .StartTx(start_tx), .ConfigDiv(cfg_div), .DivIn(div_in), .ClrOvf(clr_ovf),
        .Dout(dout), .ClkTx(clk_tx), .TxBusy(tx_busy), .TxDone(tx_done),
        .Empty(empty), .Full(full), .Level(level), .Overflow(overflow)
    );

    serial_tx_fifo #(.FRAMED(0), .MSB_FIRST(1)) dut2 (
        .Clk(Clk), .Reset(Reset), .Sample(s2_sample), .DataIn(s2_data),
        .StartTx(s2_start), .ConfigDiv(s2_cfg), .DivIn(s2_div), .ClrOvf(s2_clr),
        .Dout(d2_dout), .ClkTx(d2_clk), .TxBusy(d2_busy), .TxDone(d2_done),
        .Empty(d2_empty), .Full(d2_full), .Level(d2_level), .Overflow(d2_ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q1_word[$];
    int          q1_len[$];
    int          q1_p[$];
    logic [31:0] q2_word[$];
    int          q2_len[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the framed instance: start bit, 32 LSB-first bits, stop bit
    int          m1_cyc = 0, m1_nb = 0, m1_badph = 0;
    logic        m1_prev = 1'b0;
    logic [33:0] m1_bits;
    always @(negedge Clk) begin
        if (!Reset) begin
            m1_cyc = 0; m1_nb = 0; m1_badph = 0; m1_prev = 1'b0;
        end else begin
            if (tx_busy) m1_cyc++;
            if (clk_tx && !m1_prev) begin
                if (m1_nb < 34) m1_bits[m1_nb] = dout;
                m1_nb++;
                if (q1_p.size() > 0 && ((m1_cyc - 1) % q1_p[0]) != (q1_p[0] / 2)) m1_badph++;
            end
            m1_prev = clk_tx;
            if (tx_done) begin
                if (q1_word.size() == 0) begin
                    chk("unexpected_txdone", 1, 0);
                end else begin
                    chk("frame_bits", 64'(m1_nb), 64'd34);
                    chk("start_bit", m1_bits[0], 1'b0);
                    chk("stop_bit", m1_bits[33], 1'b1);
                    chk("payload", m1_bits[32:1], q1_word[0]);
                    chk("frame_len", 64'(m1_cyc), 64'(q1_len[0]));
                    chk("clktx_phase", 64'(m1_badph), 64'd0);
                    void'(q1_word.pop_front());
                    void'(q1_len.pop_front());
                    void'(q1_p.pop_front());
                end
                m1_cyc = 0; m1_nb = 0; m1_badph = 0;
            end
        end
    end

    // Monitor for the raw instance: 32 MSB-first bits, P=2
    int          m2_cyc = 0, m2_nb = 0, m2_badph = 0;
    logic        m2_prev = 1'b0;
    logic        m2_first;
    logic [31:0] m2_word;
    always @(negedge Clk) begin
        if (!Reset) begin
            m2_cyc = 0; m2_nb = 0; m2_badph = 0; m2_prev = 1'b0;
        end else begin
            if (d2_busy) m2_cyc++;
            if (d2_clk && !m2_prev) begin
                if (m2_nb == 0) m2_first = d2_dout;
                if (m2_nb < 32) m2_word[31 - m2_nb] = d2_dout;
                m2_nb++;
                if (((m2_cyc - 1) % 2) != 1) m2_badph++;
            end
            m2_prev = d2_clk;
            if (d2_done) begin
                if (q2_word.size() == 0) begin
                    chk("unexpected_txdone2", 1, 0);
                end else begin
                    chk("frame_bits2", 64'(m2_nb), 64'd32);
                    chk("first_bit2", m2_first, q2_word[0][31]);
                    chk("payload2", m2_word, q2_word[0]);
                    chk("frame_len2", 64'(m2_cyc), 64'(q2_len[0]));
                    chk("clktx_phase2", 64'(m2_badph), 64'd0);
                    void'(q2_word.pop_front());
                    void'(q2_len.pop_front());
                end
                m2_cyc = 0; m2_nb = 0; m2_badph = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] w, input int len, input int p, input bit track);
        sample  = 1'b1;
        data_in = w;
        cyc();
        sample  = 1'b0;
        if (track) begin
            q1_word.push_back(w);
            q1_len.push_back(len);
            q1_p.push_back(p);
        end
    endtask

    task automatic push2(input logic [31:0] w);
        s2_sample = 1'b1;
        s2_data   = w;
        cyc();
        s2_sample = 1'b0;
        q2_word.push_back(w);
        q2_len.push_back(64);
    endtask

    task automatic set_div1(input logic [7:0] d);
        cfg_div = 1'b1;
        div_in  = d;
        cyc();
        cfg_div = 1'b0;
    endtask

    task automatic wait_drain(input bit second, input int budget);
        int n = 0;
        while (n < budget && !(second ? (d2_empty && !d2_busy) : (empty && !tx_busy))) begin
            cyc();
            n++;
        end
        if (n >= budget) chk(second ? "drain_timeout2" : "drain_timeout", 1, 0);
    endtask

    initial begin
        int n;
        sample = 0; start_tx = 0; cfg_div = 0; clr_ovf = 0; data_in = '0; div_in = '0;
        s2_sample = 0; s2_start = 0; s2_cfg = 0; s2_clr = 0; s2_data = '0; s2_div = '0;
        #1 Reset = 1'b0;
        #1;
        chk("rst_dout", dout, 1'b1);
        chk("rst_ctl", {clk_tx, tx_busy, tx_done}, 3'b000);
        chk("rst_fifo", {empty, full, level, overflow}, 6'b100000);
        chk("rst_dout2", d2_dout, 1'b0);
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        cyc();

        // Single framed word at P=4
        set_div1(8'd3);
        push1(32'hA5A5_0001, 136, 4, 1'b1);
        start_tx = 1'b1;
        wait_drain(1'b0, 1000);
        start_tx = 1'b0;

        // Fill, overflow, clear
        push1(32'h1234_5678, 68, 2, 1'b1);
        push1(32'hFFFF_0000, 68, 2, 1'b1);
        push1(32'h0000_0001, 68, 2, 1'b1);
        push1(32'h8000_0000, 68, 2, 1'b1);
        chk("full_level4", {full, empty, level}, 5'b10100);
        chk("no_ovf_yet", overflow, 1'b0);
        push1(32'hDEAD_0005, 0, 0, 1'b0);
        chk("ovf_set", {overflow, level}, 4'b1100);
        sample = 1'b1; data_in = 32'hDEAD_0006; clr_ovf = 1'b1;
        cyc();
        sample = 1'b0;
        chk("ovf_set_priority", overflow, 1'b1);
        cyc();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        // Four back-to-back frames at P=2
        set_div1(8'd1);
        start_tx = 1'b1;
        cyc();
        chk("b2b_busy_start", {tx_busy, level}, 4'b1011);
        n = 0;
        while (tx_busy && n < 2000) begin
            n++;
            cyc();
        end
        start_tx = 1'b0;
        chk("b2b_total_busy", 64'(n), 64'd272);
        chk("b2b_idle_dout", {dout, empty}, 2'b11);

        // Divider change ignored mid-frame; StartTx drop does not abort
        push1(32'hC3C3_3C3C, 68, 2, 1'b1);
        start_tx = 1'b1;
        cyc();
        repeat (10) cyc();
        cfg_div = 1'b1; div_in = 8'd7;
        cyc();
        cfg_div = 1'b0;
        start_tx = 1'b0;
        wait_drain(1'b0, 1000);
        set_div1(8'd7);
        push1(32'h5555_AAAA, 272, 8, 1'b1);
        start_tx = 1'b1;
        wait_drain(1'b0, 1000);
        start_tx = 1'b0;

        // Reset mid-frame abandons everything immediately
        push1(32'hDEAD_BEEF, 0, 0, 1'b0);
        push1(32'h0F0F_0F0F, 0, 0, 1'b0);
        start_tx = 1'b1;
        cyc();
        repeat (130) cyc();
        chk("pre_reset_busy", {tx_busy, level}, 4'b1001);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_dout", dout, 1'b1);
        chk("midrst_ctl", {tx_busy, tx_done, clk_tx}, 3'b000);
        chk("midrst_fifo", {level, empty}, 4'b0001);
        start_tx = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        cyc();
        chk("post_rst_idle", {tx_busy, empty, overflow}, 3'b010);
        push1(32'h7E00_0081, 68, 2, 1'b1);
        start_tx = 1'b1;
        wait_drain(1'b0, 1000);
        start_tx = 1'b0;

        // Raw MSB-first instance, DivIn=0 gives P=2
        s2_cfg = 1'b1; s2_div = 8'd0;
        cyc();
        s2_cfg = 1'b0;
        chk("idle_dout2", d2_dout, 1'b0);
        push2(32'h8000_0000);
        push2(32'h0000_00C3);
        s2_start = 1'b1;
        wait_drain(1'b1, 1000);
        s2_start = 1'b0;
        chk("idle_dout2_after", {d2_dout, d2_busy}, 2'b00);

        repeat (4) cyc();
        chk("q1_pending", 64'(q1_word.size()), 64'd0);
        chk("q2_pending", 64'(q2_word.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_tx_fifo.md
SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 Parameters SHALL be: DATA_W=32 (frame payload bits); DEPTH=4 (FIFO entries, power of 2, AW=log2(DEPTH)); DIV_W=8 (divider width); DIV_RST=1 (divider reset value); FRAMED=1 (1: start+stop bits, 0: raw payload); MSB_FIRST=0 (payload bit order).
REQ-002 Ports SHALL be exactly, as name  direction  width  meaning:
Clk  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-low reset
Sample  in  1  push DataIn into FIFO this cycle
DataIn  in  DATA_W  payload word
StartTx  in  1  level; transmission permitted while high
ConfigDiv  in  1  load DivIn into divider register
DivIn  in  DIV_W  new divider value
ClrOvf  in  1  clear Overflow flag
Dout  out  1  serial data
ClkTx  out  1  companion bit clock, rising edge mid-bit
TxBusy  out  1  frame in progress
TxDone  out  1  one-cycle pulse at frame end
Empty  out  1  FIFO empty
Full  out  1  FIFO full
Level  out  AW+1  FIFO occupancy
Overflow  out  1  sticky: push attempted while full
REQ-003 One clock, Clk; reset is asynchronous and active-low, port Reset.

Function
REQ-004 Divider register DivReg SHALL load DivIn on ConfigDiv=1 only while state is IDLE; DivIn=0 loads 1; ConfigDiv outside IDLE is ignored.
REQ-005 Bit period P SHALL be DivReg+1 Clk cycles; tick counter cnt runs 0..DivReg within each bit.
REQ-006 ClkTx SHALL be 0 while cnt < P/2 (floor) and 1 otherwise, only when TxBusy=1; 0 when idle.
REQ-007 FIFO push: Sample=1 and (Full=0 or pop same cycle) writes DataIn at tail; Sample=1 with Full=1 and no pop drops the word and sets Overflow.
REQ-008 Overflow SHALL stay 1 until ClrOvf=1 or reset; set takes priority over simultaneous ClrOvf.
REQ-009 No bypass: a pop requires Empty=0 at the start of the cycle; push into empty FIFO is poppable the next cycle.
REQ-010 Simultaneous push and pop SHALL leave Level unchanged; Level, Empty, Full update in the same cycle as the register write.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE: when StartTx=1 and Empty=0, pop head into shift register; next state START (FRAMED=1) or DATA (FRAMED=0); TxBusy=1 from the next cycle.
REQ-013 START: Dout=0 for P cycles, then DATA.
REQ-014 DATA: DATA_W bits, each held P cycles, LSB first (MSB_FIRST=0) or MSB first; then STOP (FRAMED=1) or frame end.
REQ-015 STOP: Dout=1 for P cycles, then frame end.
REQ-016 Frame end: TxDone=1 for the last cycle of the final bit; if StartTx=1 and Empty=0 that cycle, pop next word and continue at START/DATA with no idle cycle, else IDLE with TxBusy=0 next cycle.
REQ-017 StartTx deasserted mid-frame SHALL NOT abort the frame; it only prevents the next pop.
REQ-018 Idle Dout SHALL be 1 when FRAMED=1, 0 when FRAMED=0.
REQ-019 Frame length SHALL be (DATA_W+2)*P cycles if FRAMED=1, DATA_W*P otherwise.

Reset
REQ-020 Reset=0 SHALL immediately force: state IDLE, Dout idle level, ClkTx=0, TxBusy=0, TxDone=0, Empty=1, Full=0, Level=0, Overflow=0, DivReg=DIV_RST, cnt and bit index 0.
REQ-021 Reset mid-frame SHALL abandon the frame and discard all FIFO contents; no TxDone issued.

Verification (defaults unless stated)
REQ-022 Reset, ConfigDiv=1 DivIn=3, push 32'hA5A5_0001, StartTx=1 -> Dout 0 for 4 cycles, then bit0=1, bits1..15=0, ..., stop 1; TxDone after 136 cycles; ClkTx rises on cycle 2 of each bit.
REQ-023 StartTx=0, push 5 words -> Full=1 and Level=4 after 4th; 5th dropped, Overflow=1; ClrOvf pulse -> Overflow=0.
REQ-024 Push 2 words, StartTx=1, DivIn=1 -> two frames of 68 cycles back-to-back, TxDone pulses 68 cycles apart, TxBusy never drops between them.
REQ-025 ConfigDiv=1 DivIn=7 mid-frame -> P unchanged for current frame; DivIn=7 reissued in IDLE -> next frame 272 cycles.
REQ-026 Reset=0 halfway through a frame -> Dout=1, TxBusy=0, Level=0 immediately, before next Clk edge.
REQ-027 DivIn=0, FRAMED=0, MSB_FIRST=1, push 32'h8000_0000 -> P=2, ClkTx toggles every cycle, first bit 1, frame 64 cycles, idle Dout=0.
